// File: rtl/bicubic_pkg.sv
// ============================================================================
// Module : bicubic_pkg
// Brief  : Shared Q-format constants, tap and state types, tap-distance helper
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bicubic_pkg;

  localparam int FRAC_W = 8;
  localparam int DIST_W = 10;
  localparam int ONE    = 256;
  localparam int TWO    = 512;
  localparam int WW     = 9;

  localparam logic [8:0] A_RESET = 9'd128;

  typedef enum logic [1:0] {
    TAP_M1 = 2'd0,
    TAP_0  = 2'd1,
    TAP_P1 = 2'd2,
    TAP_P2 = 2'd3
  } tap_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Distance of each tap from the sample point; f=0 puts the +2 tap at exactly 2.0.
  function automatic logic [DIST_W-1:0] tap_dist(input tap_e tap, input logic [FRAC_W-1:0] f);
    logic [DIST_W-1:0] fx;
    fx = {2'b00, f};
    case (tap)
      TAP_M1:  tap_dist = DIST_W'(ONE) + fx;
      TAP_0:   tap_dist = fx;
      TAP_P1:  tap_dist = DIST_W'(ONE) - fx;
      default: tap_dist = DIST_W'(TWO) - fx;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bicubic_tag_pipe.sv
// ============================================================================
// Module : bicubic_tag_pipe
// Brief  : KERN_LAT-deep {valid, idx} delay line tracking kernel requests
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bicubic_tag_pipe #(
  parameter int KERN_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  logic [1:0] in_idx,
  output logic       out_valid,
  output logic [1:0] out_idx
);
  import bicubic_pkg::*;

  logic [KERN_LAT-1:0]      vld_q, vld_d;
  logic [KERN_LAT-1:0][1:0] idx_q, idx_d;

  // Clearing drops the tags only; the index bits are don't-care once invalid.
  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = in_valid & ~clr;
    idx_d[0] = in_idx;
    for (int i = 1; i < KERN_LAT; i++) begin
      vld_d[i] = vld_q[i-1] & ~clr;
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_valid = vld_q[KERN_LAT-1];
  assign out_idx   = idx_q[KERN_LAT-1];

endmodule

`default_nettype wire

// File: rtl/bicubic_tap_sched.sv
// ============================================================================
// Module : bicubic_tap_sched
// Brief  : Issues four bicubic tap distances per pixel, assembles the weights
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bicubic_tap_sched #(
  parameter int KERN_LAT = 3,
  parameter int WW       = bicubic_pkg::WW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            cfg_we,
  input  logic [8:0]      cfg_a,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [7:0]      req_frac,
  output logic            k_valid,
  output logic [9:0]      k_x,
  output logic            k_far,
  output logic [8:0]      k_a,
  input  logic [WW-1:0]   k_w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*WW-1:0] out_w
);
  import bicubic_pkg::*;

  state_e                state_q, state_d;
  tap_e                  tap_q, tap_d;
  logic [FRAC_W-1:0]     frac_q, frac_d;
  logic                  k_valid_q, k_valid_d;
  logic [DIST_W-1:0]     k_x_q, k_x_d;
  logic                  k_far_q, k_far_d;
  logic [8:0]            k_a_q, k_a_d;
  logic [3:0][WW-1:0]    slot_q, slot_d;

  logic                  tag_valid;
  logic [1:0]            tag_idx;
  logic                  accept;

  // Held low through reset and in any flush cycle so no request slips in.
  assign req_ready = rst_n && (state_q == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  bicubic_tag_pipe #(
    .KERN_LAT (KERN_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .in_valid  (k_valid_q),
    .in_idx    (tap_q),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    frac_d    = frac_q;
    k_valid_d = 1'b0;
    k_x_d     = '0;
    k_far_d   = 1'b0;
    k_a_d     = k_a_q;
    slot_d    = slot_q;

    if (tag_valid && !flush) begin
      slot_d[tag_idx] = k_w;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          k_a_d = cfg_a;
        end
        if (accept) begin
          frac_d    = req_frac;
          tap_d     = TAP_M1;
          k_valid_d = 1'b1;
          k_x_d     = tap_dist(TAP_M1, req_frac);
          k_far_d   = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (tap_q == TAP_P2) begin
          state_d = ST_WAIT;
        end else begin
          tap_d     = tap_e'(tap_q + 2'd1);
          k_valid_d = 1'b1;
          k_x_d     = tap_dist(tap_d, frac_q);
          k_far_d   = (tap_d == TAP_P2);
        end
      end
      ST_WAIT: begin
        if (tag_valid && (tag_idx == TAP_P2)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d   = ST_IDLE;
      k_valid_d = 1'b0;
      k_x_d     = '0;
      k_far_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tap_q     <= TAP_M1;
      frac_q    <= '0;
      k_valid_q <= 1'b0;
      k_x_q     <= '0;
      k_far_q   <= 1'b0;
      k_a_q     <= A_RESET;
      slot_q    <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      frac_q    <= frac_d;
      k_valid_q <= k_valid_d;
      k_x_q     <= k_x_d;
      k_far_q   <= k_far_d;
      k_a_q     <= k_a_d;
      slot_q    <= slot_d;
    end
  end

  assign k_valid   = k_valid_q;
  assign k_x       = k_x_q;
  assign k_far     = k_far_q;
  assign k_a       = k_a_q;
  assign out_valid = (state_q == ST_HOLD);
  assign out_w     = slot_q;

endmodule

`default_nettype wire
